branch_result_queue: RTL and testbench

- Per-branch result buffer between one execution branch (MAC, ALU, LUT, ...) and the in-order commit stage.
- Buffers completed results tagged with block index, destination, commit ID and commit flag. Presents the oldest entry to the commit stage until it is consumed.
- One instance per instruction branch. Decouples branch completion from in-order commit so a branch can run ahead of the commit pointer by up to `depth` results.

---
 rtl/branch_result_queue.sv | 139 +++++++++++++
 tb/tb_branch_result_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_result_queue.sv
// ---------------------------------------------------------------------------
// branch_result_queue
//
// Per-branch result buffer between one execution branch (MAC, ALU, LUT, ...)
// and the in-order commit stage. Completed results are tagged with a block
// index, destination register, commit ID and commit flag. They are held in a
// small circular buffer. The oldest entry is presented to the commit stage
// until that stage consumes it. This lets a branch run ahead of the commit
// pointer by up to `depth` results.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset (overrides all)
//   flush              synchronous queue clear (program restart)
//   push_valid/ready   branch-side handshake; ready depends on count only
//   push_block/result/dest/commit_id/commit_flag   fields of the new entry
//   out_valid          head entry present (count != 0)
//   out_ready          commit stage consumed the head (one pulse per entry)
//   out_block/result/dest/commit_id/commit_flag    fields of the head entry
//   count              current occupancy, 0..depth
//   protocol_err       sticky: pop while empty or push while full
// ---------------------------------------------------------------------------
module branch_result_queue #(
    parameter int data_width = 16,
    parameter int n_blocks   = 256,
    parameter int depth      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [$clog2(n_blocks)-1:0]   push_block,
    input  logic [2*data_width-1:0]       push_result,
    input  logic [3:0]                    push_dest,
    input  logic [8:0]                    push_commit_id,
    input  logic                          push_commit_flag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(n_blocks)-1:0]   out_block,
    output logic [2*data_width-1:0]       out_result,
    output logic [3:0]                    out_dest,
    output logic [8:0]                    out_commit_id,
    output logic                          out_commit_flag,
    output logic [$clog2(depth+1)-1:0]    count,
    output logic                          protocol_err
);

    localparam int block_w = $clog2(n_blocks);
    localparam int ptr_w   = $clog2(depth);
    localparam int count_w = $clog2(depth + 1);

    localparam logic [count_w-1:0] full_count = count_w'(depth);
    localparam logic [count_w-1:0] count_one  = count_w'(1);
    localparam logic [ptr_w-1:0]   ptr_one    = ptr_w'(1);

    logic [block_w-1:0]      mem_block  [depth];
    logic [2*data_width-1:0] mem_result [depth];
    logic [3:0]              mem_dest   [depth];
    logic [8:0]              mem_id     [depth];
    logic                    mem_flag   [depth];

    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [count_w-1:0] count_q;

    logic is_full;
    logic is_empty;
    logic do_push;
    logic do_pop;
    logic err_event;

    // Status decodes come from the count register only. A pop does not
    // free a slot for a push in the same cycle, so there is no
    // combinational path from out_ready to push_ready.
    assign is_full    = (count_q == full_count);
    assign is_empty   = (count_q == '0);
    assign push_ready = !is_full;
    assign out_valid  = !is_empty;
    assign count      = count_q;

    // Illegal requests are flagged and otherwise ignored. They cannot
    // move the pointers or overwrite a resident entry.
    assign do_push   = push_valid && !is_full;
    assign do_pop    = out_ready && !is_empty;
    assign err_event = (out_ready && is_empty) || (push_valid && is_full);

    // The head is read straight from storage. A push therefore becomes
    // visible on out_* only after the edge that writes it.
    assign out_block       = mem_block[rd_ptr];
    assign out_result      = mem_result[rd_ptr];
    assign out_dest        = mem_dest[rd_ptr];
    assign out_commit_id   = mem_id[rd_ptr];
    assign out_commit_flag = mem_flag[rd_ptr];

    // Storage has no reset; its contents only matter once count covers them.
    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) begin
            mem_block[wr_ptr]  <= push_block;
            mem_result[wr_ptr] <= push_result;
            mem_dest[wr_ptr]   <= push_dest;
            mem_id[wr_ptr]     <= push_commit_id;
            mem_flag[wr_ptr]   <= push_commit_flag;
        end
    end

    // Pointer and occupancy control. Flush discards any push or pop in
    // its cycle but leaves the sticky error flag alone. Only reset clears
    // that flag. Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (err_event) begin
                protocol_err <= 1'b1;
            end
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + ptr_one;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + ptr_one;
                end
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + count_one;
                    2'b01:   count_q <= count_q - count_one;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_result_queue.sv
// ---------------------------------------------------------------------------
// tb_branch_result_queue
//
// Self-checking bench for branch_result_queue with the default parameters
// (data_width=16, n_blocks=256, depth=4). Every accepted push is recorded in
// a scoreboard queue. Every pop compares the presented head against the
// oldest scoreboard entry. Occupancy, handshake and error status are
// compared against the bench's own view of the queue.
// ---------------------------------------------------------------------------
module tb_branch_result_queue;

    localparam int data_width = 16;
    localparam int n_blocks   = 256;
    localparam int depth      = 4;

    typedef struct packed {
        logic [7:0]  blk;
        logic [31:0] res;
        logic [3:0]  dest;
        logic [8:0]  id;
        logic        flag;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [7:0]  push_block;
    logic [31:0] push_result;
    logic [3:0]  push_dest;
    logic [8:0]  push_commit_id;
    logic        push_commit_flag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_block;
    logic [31:0] out_result;
    logic [3:0]  out_dest;
    logic [8:0]  out_commit_id;
    logic        out_commit_flag;
    logic [2:0]  count;
    logic        protocol_err;

    entry_t sb[$];
    logic   model_err;
    int     checks;
    int     failures;

    branch_result_queue #(
        .data_width(data_width),
        .n_blocks  (n_blocks),
        .depth     (depth)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .push_valid      (push_valid),
        .push_ready      (push_ready),
        .push_block      (push_block),
        .push_result     (push_result),
        .push_dest       (push_dest),
        .push_commit_id  (push_commit_id),
        .push_commit_flag(push_commit_flag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_block       (out_block),
        .out_result      (out_result),
        .out_dest        (out_dest),
        .out_commit_id   (out_commit_id),
        .out_commit_flag (out_commit_flag),
        .count           (count),
        .protocol_err    (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fields of an entry derived from its commit ID. ID 0 gives
    // result 0x00012345 and dest 3.
    function automatic entry_t makeEntry(input logic [8:0] id);
        entry_t e;
        e.blk  = 8'(id * 5 + 1);
        e.res  = 32'h0001_2345 + 32'(id) * 32'h0101_0101;
        e.dest = 4'(id + 3);
        e.id   = id;
        e.flag = id[0];
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_count"}, 64'(count), 64'(sb.size()));
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
        checkOutput({tag, "_push_ready"}, 64'(push_ready), 64'(sb.size() != depth));
        checkOutput({tag, "_protocol_err"}, 64'(protocol_err), 64'(model_err));
    endtask

    // Drives one clock cycle from a negedge to the next negedge. A pop
    // first compares the current head with the scoreboard front.
    task automatic applyStimulus(input logic pv, input logic [8:0] id,
                                 input logic orr, input logic fl);
        entry_t e;
        int     pre_size;
        e        = makeEntry(id);
        pre_size = sb.size();
        if (orr && !fl && pre_size > 0) begin
            checkOutput("head_entry",
                        64'({out_block, out_result, out_dest, out_commit_id, out_commit_flag}),
                        64'(sb[0]));
        end
        push_valid       = pv;
        push_block       = e.blk;
        push_result      = e.res;
        push_dest        = e.dest;
        push_commit_id   = e.id;
        push_commit_flag = e.flag;
        out_ready        = orr;
        flush            = fl;
        if ((orr && pre_size == 0) || (pv && pre_size == depth)) begin
            model_err = 1'b1;
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (orr && pre_size > 0) void'(sb.pop_front());
            if (pv && pre_size < depth) sb.push_back(e);
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        model_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        model_err        = 1'b0;
        reset            = 1'b1;
        flush            = 1'b0;
        push_valid       = 1'b0;
        out_ready        = 1'b0;
        push_block       = '0;
        push_result      = '0;
        push_dest        = '0;
        push_commit_id   = '0;
        push_commit_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkStatus("reset");

        // Single push into an empty queue, then a single pop.
        applyStimulus(1'b1, 9'd0, 1'b0, 1'b0);
        checkStatus("single_push");
        checkOutput("single_result", 64'(out_result), 64'h0001_2345);
        checkOutput("single_dest", 64'(out_dest), 64'd3);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
        checkStatus("single_pop");

        // Fill to depth, overrun once, then drain in order.
        for (int i = 0; i < depth; i++) applyStimulus(1'b1, 9'(i), 1'b0, 1'b0);
        checkStatus("full");
        applyStimulus(1'b1, 9'd4, 1'b0, 1'b0);
        checkStatus("overrun");
        checkOutput("overrun_head_id", 64'(out_commit_id), 64'd0);
        for (int i = 0; i < depth; i++) applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
        checkStatus("drained");

        // Two resident entries with simultaneous push and pop across a wrap.
        doReset();
        checkStatus("reset2");
        applyStimulus(1'b1, 9'd100, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd101, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 9'(102 + k), 1'b1, 1'b0);
            checkOutput("steady_count", 64'(count), 64'd2);
        end
        checkStatus("steady_end");
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
        checkStatus("steady_drain");

        // Pop request on an empty queue.
        doReset();
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
        checkStatus("underrun");
        applyStimulus(1'b1, 9'd5, 1'b0, 1'b0);
        checkOutput("underrun_head_id", 64'(out_commit_id), 64'd5);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
        checkStatus("underrun_after");

        // Flush with a simultaneous push and pop.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 9'(20 + i), 1'b0, 1'b0);
        checkStatus("pre_flush");
        applyStimulus(1'b1, 9'd7, 1'b1, 1'b1);
        checkStatus("flush");
        applyStimulus(1'b1, 9'd9, 1'b0, 1'b0);
        checkStatus("post_flush_push");
        checkOutput("post_flush_head_id", 64'(out_commit_id), 64'd9);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
        checkStatus("post_flush_pop");

        // Reset mid-burst with an error already flagged.
        doReset();
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 9'd30, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd31, 1'b0, 1'b0);
        checkStatus("pre_reset");
        reset      = 1'b1;
        push_valid = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        push_valid = 1'b0;
        sb.delete();
        model_err = 1'b0;
        @(negedge clk);
        checkStatus("mid_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
